// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM ramp controller and the UART command decoder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package pwm_ctrl_pkg;

    // Default PWM resolution and step-timer width; ramp_cmd_t is sized from these.
    localparam int PWM_R  = 8;
    localparam int PWM_TW = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    // One ramp command: target duty (0..2^R, so R+1 bits) and step period minus one.
    typedef struct packed {
        logic [PWM_R:0]    duty;
        logic [PWM_TW-1:0] step;
    } ramp_cmd_t;

    // Full-scale duty code: 2^r means 100% on-time.
    function automatic int unsigned duty_max(input int unsigned r);
        return 32'd1 << r;
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Free-running TW-bit step counter: counts 0..period_i and wraps, tick_o on the last count.
// Latency: tick_o is combinational from the count; clear takes effect on the next edge.
// Backpressure: none; clr_i has priority over en_i.
module pwm_step_timer #(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [TW-1:0] period_i,
    output logic          tick_o
);

    logic [TW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == period_i);

    // Count while enabled, wrap to zero after the terminal count, restart on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty sequencer for the PWM core: ramps duty one LSB per step period toward a commanded target, pulses done.
// Latency: first duty change step+1 cycles after accept; an N-LSB ramp takes N*(step+1) cycles.
// Backpressure: cmd_ready only in IDLE; with PWM_RAMP_QUEUE_EN defined a one-entry buffer accepts a command mid-ramp.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int R  = PWM_R,
    parameter int TW = PWM_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [R:0]    cmd_duty,
    input  logic [TW-1:0] cmd_step,
    input  logic          abort,
    output logic [R:0]    duty,
    output logic          busy,
    output logic          done
);

    localparam logic [R:0] DMAX = (R+1)'(duty_max(R));

    ramp_state_t   state_q;
    logic [R:0]    duty_q;
    logic [R:0]    tgt_q;
    logic [TW-1:0] step_q;
    logic          done_q;

    logic          tick;
    logic          accept;
    ramp_cmd_t     in_cmd;
    ramp_cmd_t     load_cmd_d;
    logic          load_vld_d;
    logic [R:0]    duty_step_d;
    logic          fin_d;

`ifdef PWM_RAMP_QUEUE_EN
    logic          buf_vld_q;
    ramp_cmd_t     buf_q;
    logic          pend_vld_d;

    assign cmd_ready = !buf_vld_q;
`else
    assign cmd_ready = (state_q == IDLE);
`endif

    assign accept = cmd_valid && cmd_ready;
    assign duty   = duty_q;
    assign busy   = (state_q == RAMP);
    assign done   = done_q;

    // Clamp the incoming target, compute the next duty step and decide whether a command loads this cycle.
    always_comb begin
        in_cmd.duty = (cmd_duty > DMAX) ? DMAX : cmd_duty;
        in_cmd.step = cmd_step;
        duty_step_d = (tgt_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
        fin_d       = (state_q == RAMP) && !abort && tick && (duty_step_d == tgt_q);
        load_vld_d  = 1'b0;
        load_cmd_d  = in_cmd;
`ifdef PWM_RAMP_QUEUE_EN
        // A buffered command takes precedence over the port; the port cannot accept while it is full.
        pend_vld_d = buf_vld_q || accept;
        load_cmd_d = buf_vld_q ? buf_q : in_cmd;
        if (state_q == IDLE) begin
            // Hold a buffered no-move command one cycle after a done so each command gets a distinct pulse.
            load_vld_d = pend_vld_d && !(buf_vld_q && done_q);
        end else begin
            // Chain straight into the next ramp only if it actually moves; otherwise let IDLE pulse its done.
            load_vld_d = fin_d && pend_vld_d && (load_cmd_d.duty != duty_step_d);
        end
`else
        load_vld_d = (state_q == IDLE) && accept;
`endif
    end

    pwm_step_timer #(
        .TW(TW)
    ) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (load_vld_d),
        .en_i     (state_q == RAMP),
        .period_i (step_q),
        .tick_o   (tick)
    );

    // Ramp FSM: latch commands, step duty on each tick, stop and pulse done at the target, stop silently on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_vld_d) begin
                        tgt_q  <= load_cmd_d.duty;
                        step_q <= load_cmd_d.step;
                        if (load_cmd_d.duty == duty_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        duty_q <= duty_step_d;
                        if (fin_d) begin
                            done_q <= 1'b1;
                            if (load_vld_d) begin
                                tgt_q  <= load_cmd_d.duty;
                                step_q <= load_cmd_d.step;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PWM_RAMP_QUEUE_EN
    // One-entry buffer: filled by a mid-ramp accept, drained when loaded, flushed by abort (including a same-cycle accept).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld_q <= 1'b0;
            buf_q     <= '0;
        end else if ((state_q == RAMP) && abort) begin
            buf_vld_q <= 1'b0;
        end else if (load_vld_d && buf_vld_q) begin
            buf_vld_q <= 1'b0;
        end else if ((state_q == RAMP) && accept && !load_vld_d) begin
            buf_vld_q <= 1'b1;
            buf_q     <= in_cmd;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps up/down, clamp, abort, async reset, optional queued command.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Every comparison is an immediate assertion that counts and reports its own failure.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_duty;
    logic [31:0] cmd_step;
    logic        abort;
    logic [8:0]  duty;
    logic        busy;
    logic        done;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_duty  (cmd_duty),
        .cmd_step  (cmd_step),
        .abort     (abort),
        .duty      (duty),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one edge (it is accepted there when cmd_ready is high).
    task automatic send(input int d, input int s, input logic ab);
        cmd_valid = 1'b1;
        cmd_duty  = 9'(d);
        cmd_step  = 32'(s);
        abort     = ab;
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    // Follow a just-accepted ramp cycle by cycle against the closed-form expected duty.
    task automatic ramp(input int start, input int tgt, input int step);
        int n     = (tgt > start) ? tgt - start : start - tgt;
        int total = n * (step + 1);
        chk("ramp_busy_start", busy, 1);
        chk("ramp_duty_start", duty, start);
        for (int k = 1; k <= total; k++) begin
            int mv = k / (step + 1);
            int e  = (tgt > start) ? start + mv : start - mv;
            tick();
            chk("ramp_duty", duty, e);
            chk("ramp_done", done, (k == total));
            chk("ramp_busy", busy, (k != total));
`ifndef PWM_RAMP_QUEUE_EN
            if (k != total) chk("ramp_ready_low", cmd_ready, 0);
`endif
        end
        chk("ramp_ready_end", cmd_ready, 1);
        tick();
        chk("ramp_done_clear", done, 0);
        chk("ramp_duty_hold", duty, tgt);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_duty  = '0;
        cmd_step  = '0;
        abort     = 1'b0;

        // Reset state
        #12;
        chk("rst_duty", duty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", cmd_ready, 1);

        // 0 -> 4, step 2: changes at cycles 3,6,9,12
        send(4, 2, 1'b0);
        ramp(0, 4, 2);

        // 4 -> 1, step 0: one LSB per cycle downward
        send(1, 0, 1'b0);
        ramp(4, 1, 0);

        // Climb to 250, then a 300 target clamps to 256
        send(250, 0, 1'b0);
        ramp(1, 250, 0);
        send(300, 0, 1'b0);
        ramp(250, 256, 0);
        tick();
        chk("clamp_hold", duty, 256);

        // Async reset between edges mid-ramp
        send(0, 3, 1'b0);
        tick();
        tick();
        chk("pre_rst_duty", duty, 256);
        chk("pre_rst_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_duty", duty, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_ready", cmd_ready, 1);

`ifdef PWM_RAMP_QUEUE_EN
        // Queued command: 0->3 then 3->0, no IDLE gap, dones 3 cycles apart
        send(3, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd_duty  = 9'd0;
        cmd_step  = 32'd0;
        tick();
        cmd_valid = 1'b0;
        chk("q_duty1", duty, 1);
        chk("q_ready_full", cmd_ready, 0);
        tick();
        chk("q_duty2", duty, 2);
        chk("q_ready_full2", cmd_ready, 0);
        chk("q_done_early", done, 0);
        tick();
        chk("q_duty3", duty, 3);
        chk("q_done1", done, 1);
        chk("q_busy_chain", busy, 1);
        chk("q_ready_free", cmd_ready, 1);
        tick();
        chk("q_duty_down2", duty, 2);
        chk("q_done_clr", done, 0);
        chk("q_busy_mid", busy, 1);
        tick();
        chk("q_duty_down1", duty, 1);
        tick();
        chk("q_duty0", duty, 0);
        chk("q_done2", done, 1);
        chk("q_busy_end", busy, 0);
`endif

        // 0 -> 100 step 9, abort at cycle 55: duty holds 5
        send(100, 9, 1'b0);
        chk("ab_busy", busy, 1);
        for (int k = 1; k <= 54; k++) begin
            tick();
            chk("ab_duty", duty, k / 10);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_hold_duty", duty, 5);
        chk("ab_busy_low", busy, 0);
        chk("ab_no_done", done, 0);
        chk("ab_ready", cmd_ready, 1);

        // Command equal to current duty: immediate done, no change
        send(5, 0, 1'b0);
        chk("eq_done", done, 1);
        chk("eq_duty", duty, 5);
        chk("eq_busy", busy, 0);
        tick();
        chk("eq_done_clr", done, 0);

        // Abort coinciding with a tick wins: duty does not move
        send(8, 1, 1'b0);
        tick();
        chk("abt_tick_pre", duty, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_tick_duty", duty, 5);
        chk("abt_tick_busy", busy, 0);
        chk("abt_tick_done", done, 0);

        // Abort alone in IDLE is ignored; abort with a command in IDLE still accepts it
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_duty", duty, 5);
        send(7, 0, 1'b1);
        ramp(5, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
